// File: rtl/ycr2_wb_bridge.sv
// Wishbone master stage behind the per-target router: runs core single and burst
// transfers as classic WB cycles, with per-beat response, bus error and timeout.
//
// state | meaning
// IDLE  | no WB cycle open; a new core request is accepted here
// BUS   | cyc/stb asserted, waiting for ack, err or timeout on the current beat
// WDAT  | write burst between beats; cyc held, stb low, waiting for next write data
`timescale 1ns/1ps
module ycr2_wb_bridge #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int BW     = 10,
   parameter int TOUT_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          core_req,
   output logic          core_req_ack,
   input  logic          core_cmd,
   input  logic [1:0]    core_width,
   input  logic [AW-1:0] core_addr,
   input  logic [BW-1:0] core_bl,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic [1:0]    core_resp,
   output logic          wbm_cyc_o,
   output logic          wbm_stb_o,
   output logic          wbm_we_o,
   output logic [AW-1:0] wbm_adr_o,
   output logic [DW-1:0] wbm_dat_o,
   output logic [3:0]    wbm_sel_o,
   input  logic [DW-1:0] wbm_dat_i,
   input  logic          wbm_ack_i,
   input  logic          wbm_err_i
);

   localparam logic [1:0] RESP_NOTRDY = 2'b00;
   localparam logic [1:0] RESP_OK     = 2'b01;
   localparam logic [1:0] RESP_ER     = 2'b10;
   localparam logic [1:0] RESP_LOK    = 2'b11;

   // A zero-width timer is not legal, so a 1-bit dummy is kept and gated off.
   localparam int TW      = (TOUT_W > 0) ? TOUT_W : 1;
   localparam bit TOUT_EN = (TOUT_W > 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_WDAT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic          cyc_q, cyc_d;
   logic          stb_q, stb_d;
   logic          we_q, we_d;
   logic [1:0]    width_q, width_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [DW-1:0] dat_q, dat_d;
   logic [3:0]    sel_q, sel_d;
   logic [BW-1:0] beats_q, beats_d;
   logic [TW-1:0] tout_q, tout_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [1:0]    resp_q, resp_d;

   logic          last_beat;
   logic          tout_fire;
   logic [TW-1:0] tout_inc;
   logic [AW-1:0] adr_nxt;

   function automatic logic [3:0] lane_sel(input logic [1:0] w, input logic [1:0] a);
      case (w)
         2'd0:    lane_sel = 4'b0001 << a;
         2'd1:    lane_sel = a[1] ? 4'b1100 : 4'b0011;
         default: lane_sel = 4'b1111;
      endcase
   endfunction

   function automatic logic [AW-1:0] addr_step(input logic [1:0] w);
      case (w)
         2'd0:    addr_step = AW'(1);
         2'd1:    addr_step = AW'(2);
         default: addr_step = AW'(4);
      endcase
   endfunction

   assign last_beat = (beats_q == BW'(1));
   assign adr_nxt   = adr_q + addr_step(width_q);
   assign tout_inc  = tout_q + TW'(1);
   assign tout_fire = TOUT_EN && (state_q == ST_BUS) && !wbm_ack_i && !wbm_err_i
                      && (&tout_inc);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (core_req) state_d = ST_BUS;
         ST_BUS: begin
            if (wbm_err_i || tout_fire) state_d = ST_IDLE;
            else if (wbm_ack_i) begin
               if (last_beat) state_d = ST_IDLE;
               else if (we_q) state_d = ST_WDAT;
               else           state_d = ST_BUS;
            end
         end
         ST_WDAT: if (core_req) state_d = ST_BUS;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      core_req_ack = core_req && ((state_q == ST_IDLE) || (state_q == ST_WDAT));
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      we_d    = we_q;
      width_d = width_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      beats_d = beats_q;
      tout_d  = tout_q;
      rdata_d = rdata_q;
      resp_d  = RESP_NOTRDY;
      case (state_q)
         ST_IDLE: begin
            if (core_req) begin
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = core_cmd;
               width_d = core_width;
               adr_d   = core_addr;
               dat_d   = core_wdata;
               sel_d   = lane_sel(core_width, core_addr[1:0]);
               beats_d = (core_bl == '0) ? BW'(1) : core_bl;
               tout_d  = '0;
            end
         end
         ST_BUS: begin
            if (wbm_err_i || tout_fire) begin
               resp_d  = RESP_ER;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               we_d    = 1'b0;
               beats_d = '0;
               tout_d  = '0;
            end else if (wbm_ack_i) begin
               resp_d  = last_beat ? RESP_LOK : RESP_OK;
               if (!we_q) rdata_d = wbm_dat_i;
               beats_d = beats_q - BW'(1);
               adr_d   = adr_nxt;
               sel_d   = lane_sel(width_q, adr_nxt[1:0]);
               tout_d  = '0;
               if (last_beat) begin
                  cyc_d = 1'b0;
                  stb_d = 1'b0;
                  we_d  = 1'b0;
               end else if (we_q) begin
                  stb_d = 1'b0;
               end
            end else if (TOUT_EN) begin
               tout_d = tout_inc;
            end
         end
         ST_WDAT: begin
            // Only the data of a continuing write is taken; cmd/addr/width are stale here.
            if (core_req) begin
               dat_d  = core_wdata;
               stb_d  = 1'b1;
               tout_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         width_q <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         beats_q <= '0;
         tout_q  <= '0;
         rdata_q <= '0;
         resp_q  <= RESP_NOTRDY;
      end else begin
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         width_q <= width_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         beats_q <= beats_d;
         tout_q  <= tout_d;
         rdata_q <= rdata_d;
         resp_q  <= resp_d;
      end
   end

   assign wbm_cyc_o  = cyc_q;
   assign wbm_stb_o  = stb_q;
   assign wbm_we_o   = we_q;
   assign wbm_adr_o  = adr_q;
   assign wbm_dat_o  = dat_q;
   assign wbm_sel_o  = sel_q;
   assign core_rdata = rdata_q;
   assign core_resp  = resp_q;

endmodule

// File: tb/tb_ycr2_wb_bridge.sv
// Bench for ycr2_wb_bridge: drives core requests and a WB slave, and compares
// observed beats/responses against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ycr2_wb_bridge;
   localparam int AW = 32, DW = 32, BW = 10, TOUT_W = 4;
   localparam int TOUT_STALL = (1 << TOUT_W) - 1;

   logic          clk, rst_n;
   logic          core_req, core_req_ack, core_cmd;
   logic [1:0]    core_width, core_resp;
   logic [AW-1:0] core_addr;
   logic [BW-1:0] core_bl;
   logic [DW-1:0] core_wdata, core_rdata;
   logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i;
   logic [AW-1:0] wbm_adr_o;
   logic [DW-1:0] wbm_dat_o, wbm_dat_i;
   logic [3:0]    wbm_sel_o;

   ycr2_wb_bridge #(.AW(AW), .DW(DW), .BW(BW), .TOUT_W(TOUT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_req_ack(core_req_ack), .core_cmd(core_cmd),
      .core_width(core_width), .core_addr(core_addr), .core_bl(core_bl),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .core_resp(core_resp),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0, total = 0;
   int bad_ctl, n_reqack, exp_nack;
   logic [68:0] obs_beat[$], exp_beat[$];   // {adr, sel, we, wdata-or-0}
   logic [33:0] obs_rsp[$], exp_rsp[$];     // {resp, rdata} for every non-NOTRDY cycle
   logic [31:0] txn_rd[$], txn_wd[$];
   logic [31:0] model_rdata;

   task automatic clear_obs();
      obs_beat.delete(); exp_beat.delete(); obs_rsp.delete(); exp_rsp.delete();
      bad_ctl = 0; n_reqack = 0; exp_nack = 0;
   endtask

   task automatic sample_cycle();
      if (core_req_ack) n_reqack++;
      if (core_resp != 2'b00) obs_rsp.push_back({core_resp, core_rdata});
   endtask

   function automatic logic [3:0] model_sel(input logic [1:0] w, input logic [31:0] a);
      int off;
      off = int'(a % 4);
      if (w == 2'd0)      return 4'(1 << off);
      else if (w == 2'd1) return 4'(3 << ((off / 2) * 2));
      else                return 4'hF;
   endfunction

   // Transaction-level expectations: beat i lives at addr + i*size, the final beat is
   // locked, an error ends the burst, a stalled beat times out after 2^TOUT_W-1 cycles.
   function automatic void model_txn(input bit cmd, input logic [1:0] w, input logic [31:0] addr,
                                     input logic [9:0] bl, input int err_beat, input int tout_beat);
      int n, step, nb;
      logic [31:0] a;
      n    = (bl == 0) ? 1 : int'(bl);
      step = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      nb   = (tout_beat >= 0) ? tout_beat : (err_beat >= 0) ? err_beat + 1 : n;
      for (int i = 0; i < nb; i++) begin
         a = addr + 32'(i * step);
         exp_beat.push_back({a, model_sel(w, a), cmd, cmd ? txn_wd[i] : 32'h0});
         if (i == err_beat) exp_rsp.push_back({2'b10, model_rdata});
         else begin
            if (!cmd) model_rdata = txn_rd[i];
            exp_rsp.push_back({(i == n - 1) ? 2'b11 : 2'b01, model_rdata});
         end
      end
      if (tout_beat >= 0) exp_rsp.push_back({2'b10, model_rdata});
      exp_nack += cmd ? ((tout_beat >= 0) ? tout_beat + 1 : nb) : 1;
   endfunction

   // Core master plus WB slave for one transaction; records what the DUT did.
   task automatic do_txn(input bit cmd, input logic [1:0] width, input logic [31:0] addr,
                         input logic [9:0] bl, input int err_beat, input int tout_beat,
                         input int wait_fix, input logic [31:0] seed, input int trail);
      int n, w;
      logic [31:0] d;
      n = (bl == 0) ? 1 : int'(bl);
      txn_rd.delete(); txn_wd.delete();
      d = (seed != 0) ? seed : $urandom;
      txn_wd.push_back(d);
      core_req = 1'b1; core_cmd = cmd; core_width = width; core_addr = addr;
      core_bl = bl; core_wdata = d;
      #1; if (wbm_cyc_o) bad_ctl++;
      sample_cycle();
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         w = (i == tout_beat) ? TOUT_STALL : (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 4));
         for (int c = 0; c < w; c++) begin
            core_req = 1'($urandom); core_addr = $urandom; core_width = 2'($urandom);
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
            #1; if (!(wbm_cyc_o && wbm_stb_o)) bad_ctl++;
            sample_cycle();
            @(posedge clk); #1;
         end
         if (i == tout_beat) break;
         d = (seed != 0) ? seed + 32'(i) * 32'h11 : $urandom;
         if (!cmd) txn_rd.push_back(d);
         core_req = 1'($urandom); wbm_ack_i = 1'b1; wbm_err_i = (i == err_beat); wbm_dat_i = d;
         #1; if (!(wbm_cyc_o && wbm_stb_o)) bad_ctl++;
         sample_cycle();
         obs_beat.push_back({wbm_adr_o, wbm_sel_o, wbm_we_o, cmd ? wbm_dat_o : 32'h0});
         @(posedge clk); #1;
         wbm_ack_i = 1'b0; wbm_err_i = 1'b0; core_req = 1'b0;
         if (i == err_beat || i == n - 1) break;
         if (cmd) begin
            w = int'($urandom_range(0, 2));
            for (int g = 0; g < w; g++) begin
               core_req = 1'b0;
               #1; if (!wbm_cyc_o || wbm_stb_o) bad_ctl++;
               sample_cycle();
               @(posedge clk); #1;
            end
            d = (seed != 0) ? seed + 32'(i + 1) * 32'h11 : $urandom;
            txn_wd.push_back(d);
            core_req = 1'b1; core_wdata = d;
            core_cmd = 1'($urandom); core_addr = $urandom; core_width = 2'($urandom);
            #1; if (!wbm_cyc_o || wbm_stb_o) bad_ctl++;
            sample_cycle();
            @(posedge clk); #1;
            core_req = 1'b0;
         end
      end
      for (int t = 0; t < trail; t++) begin
         core_req = 1'b0;
         #1; if (wbm_cyc_o || wbm_stb_o || wbm_we_o) bad_ctl++;
         sample_cycle();
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; core_req = 1'b0; core_cmd = 1'b0; core_width = 2'd0; core_addr = '0;
      core_bl = '0; core_wdata = '0; wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1;
      total++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b000)
         $display("FAIL reset_ctl actual=%b required=000", {wbm_cyc_o, wbm_stb_o, wbm_we_o}); else passed++;
      total++; if ({wbm_adr_o, wbm_dat_o, wbm_sel_o} !== 68'h0)
         $display("FAIL reset_bus actual=%h required=0", {wbm_adr_o, wbm_dat_o, wbm_sel_o}); else passed++;
      total++; if ({core_resp, core_rdata, core_req_ack} !== 35'h0)
         $display("FAIL reset_core actual=%h required=0", {core_resp, core_rdata, core_req_ack}); else passed++;
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; rst_n = 1'b1;
      model_rdata = 32'h0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_read();
      clear_obs();
      do_txn(1'b0, 2'd2, 32'h100, 10'd1, -1, -1, 2, 32'hDEADBEEF, 2);
      model_txn(1'b0, 2'd2, 32'h100, 10'd1, -1, -1);
      total++; if (obs_beat.size() != exp_beat.size())
         $display("FAIL single_read beats actual=%0d required=%0d", obs_beat.size(), exp_beat.size()); else passed++;
      foreach (exp_beat[i]) begin
         total++; if (i >= obs_beat.size() || obs_beat[i] !== exp_beat[i])
            $display("FAIL single_read beat%0d actual=%h required=%h", i, obs_beat[i], exp_beat[i]); else passed++;
      end
      foreach (exp_rsp[i]) begin
         total++; if (i >= obs_rsp.size() || obs_rsp[i] !== exp_rsp[i])
            $display("FAIL single_read resp%0d actual=%h required=%h", i, obs_rsp[i], exp_rsp[i]); else passed++;
      end
      total++; if (obs_rsp.size() != exp_rsp.size() || n_reqack != exp_nack || bad_ctl != 0)
         $display("FAIL single_read misc actual=%0d/%0d/%0d required=%0d/%0d/0",
                  obs_rsp.size(), n_reqack, bad_ctl, exp_rsp.size(), exp_nack); else passed++;
   endtask

   task automatic test_read_burst();
      clear_obs();
      do_txn(1'b0, 2'd2, 32'h200, 10'd4, -1, -1, 0, 32'h0, 2);
      model_txn(1'b0, 2'd2, 32'h200, 10'd4, -1, -1);
      total++; if (obs_beat.size() != exp_beat.size())
         $display("FAIL read_burst beats actual=%0d required=%0d", obs_beat.size(), exp_beat.size()); else passed++;
      foreach (exp_beat[i]) begin
         total++; if (i >= obs_beat.size() || obs_beat[i] !== exp_beat[i])
            $display("FAIL read_burst beat%0d actual=%h required=%h", i, obs_beat[i], exp_beat[i]); else passed++;
      end
      foreach (exp_rsp[i]) begin
         total++; if (i >= obs_rsp.size() || obs_rsp[i] !== exp_rsp[i])
            $display("FAIL read_burst resp%0d actual=%h required=%h", i, obs_rsp[i], exp_rsp[i]); else passed++;
      end
      total++; if (obs_rsp.size() != exp_rsp.size() || n_reqack != exp_nack || bad_ctl != 0)
         $display("FAIL read_burst misc actual=%0d/%0d/%0d required=%0d/%0d/0",
                  obs_rsp.size(), n_reqack, bad_ctl, exp_rsp.size(), exp_nack); else passed++;
   endtask

   task automatic test_byte_write();
      clear_obs();
      do_txn(1'b1, 2'd0, 32'h103, 10'd2, -1, -1, -1, 32'hAA, 2);
      model_txn(1'b1, 2'd0, 32'h103, 10'd2, -1, -1);
      foreach (exp_beat[i]) begin
         total++; if (i >= obs_beat.size() || obs_beat[i] !== exp_beat[i])
            $display("FAIL byte_write beat%0d actual=%h required=%h", i, obs_beat[i], exp_beat[i]); else passed++;
      end
      foreach (exp_rsp[i]) begin
         total++; if (i >= obs_rsp.size() || obs_rsp[i] !== exp_rsp[i])
            $display("FAIL byte_write resp%0d actual=%h required=%h", i, obs_rsp[i], exp_rsp[i]); else passed++;
      end
      total++; if (obs_beat.size() != exp_beat.size() || obs_rsp.size() != exp_rsp.size() ||
                   n_reqack != exp_nack || bad_ctl != 0)
         $display("FAIL byte_write misc actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/0", obs_beat.size(),
                  obs_rsp.size(), n_reqack, bad_ctl, exp_beat.size(), exp_rsp.size(), exp_nack); else passed++;
   endtask

   task automatic test_error_midburst();
      clear_obs();
      do_txn(1'b0, 2'd2, 32'h300, 10'd3, 1, -1, -1, 32'h0, 2);
      model_txn(1'b0, 2'd2, 32'h300, 10'd3, 1, -1);
      foreach (exp_beat[i]) begin
         total++; if (i >= obs_beat.size() || obs_beat[i] !== exp_beat[i])
            $display("FAIL err_burst beat%0d actual=%h required=%h", i, obs_beat[i], exp_beat[i]); else passed++;
      end
      foreach (exp_rsp[i]) begin
         total++; if (i >= obs_rsp.size() || obs_rsp[i] !== exp_rsp[i])
            $display("FAIL err_burst resp%0d actual=%h required=%h", i, obs_rsp[i], exp_rsp[i]); else passed++;
      end
      total++; if (obs_beat.size() != exp_beat.size() || obs_rsp.size() != exp_rsp.size() ||
                   n_reqack != exp_nack || bad_ctl != 0)
         $display("FAIL err_burst misc actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/0", obs_beat.size(),
                  obs_rsp.size(), n_reqack, bad_ctl, exp_beat.size(), exp_rsp.size(), exp_nack); else passed++;
   endtask

   task automatic test_timeout();
      clear_obs();
      do_txn(1'b0, 2'd1, 32'h402, 10'd3, -1, 1, -1, 32'h0, 0);
      model_txn(1'b0, 2'd1, 32'h402, 10'd3, -1, 1);
      do_txn(1'b1, 2'd2, 32'h500, 10'd1, -1, -1, 1, 32'h0, 2);
      model_txn(1'b1, 2'd2, 32'h500, 10'd1, -1, -1);
      foreach (exp_beat[i]) begin
         total++; if (i >= obs_beat.size() || obs_beat[i] !== exp_beat[i])
            $display("FAIL timeout beat%0d actual=%h required=%h", i, obs_beat[i], exp_beat[i]); else passed++;
      end
      foreach (exp_rsp[i]) begin
         total++; if (i >= obs_rsp.size() || obs_rsp[i] !== exp_rsp[i])
            $display("FAIL timeout resp%0d actual=%h required=%h", i, obs_rsp[i], exp_rsp[i]); else passed++;
      end
      total++; if (obs_beat.size() != exp_beat.size() || obs_rsp.size() != exp_rsp.size() ||
                   n_reqack != exp_nack || bad_ctl != 0)
         $display("FAIL timeout misc actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/0", obs_beat.size(),
                  obs_rsp.size(), n_reqack, bad_ctl, exp_beat.size(), exp_rsp.size(), exp_nack); else passed++;
   endtask

   task automatic test_reset_in_wdat();
      core_req = 1'b1; core_cmd = 1'b1; core_width = 2'd2; core_addr = 32'h40;
      core_bl = 10'd4; core_wdata = 32'h1111_2222;
      @(posedge clk); #1;
      core_req = 1'b0; wbm_ack_i = 1'b1; wbm_dat_i = 32'h0;
      @(posedge clk); #1;
      wbm_ack_i = 1'b0;
      total++; if ({wbm_cyc_o, wbm_stb_o, core_resp} !== 4'b1001)
         $display("FAIL wdat_entry actual=%b required=1001", {wbm_cyc_o, wbm_stb_o, core_resp}); else passed++;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== 71'h0)
         $display("FAIL wdat_reset_bus actual=%h required=0",
                  {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o}); else passed++;
      total++; if ({core_resp, core_rdata} !== 34'h0)
         $display("FAIL wdat_reset_core actual=%h required=0", {core_resp, core_rdata}); else passed++;
      model_rdata = 32'h0;
      clear_obs();
      do_txn(1'b0, 2'd0, 32'h61, 10'd2, -1, -1, -1, 32'h0, 2);
      model_txn(1'b0, 2'd0, 32'h61, 10'd2, -1, -1);
      foreach (exp_rsp[i]) begin
         total++; if (i >= obs_rsp.size() || obs_rsp[i] !== exp_rsp[i])
            $display("FAIL post_reset resp%0d actual=%h required=%h", i, obs_rsp[i], exp_rsp[i]); else passed++;
      end
      total++; if (obs_beat.size() != exp_beat.size() || obs_beat[0] !== exp_beat[0] ||
                   n_reqack != exp_nack || bad_ctl != 0)
         $display("FAIL post_reset misc actual=%h/%0d/%0d required=%h/%0d/0",
                  obs_beat[0], n_reqack, bad_ctl, exp_beat[0], exp_nack); else passed++;
   endtask

   task automatic test_back_to_back();
      bit          cmd;
      logic [1:0]  w;
      logic [31:0] a;
      logic [9:0]  bl;
      int          n, eb;
      clear_obs();
      for (int k = 0; k < 24; k++) begin
         cmd = 1'($urandom);
         w   = 2'($urandom);
         a   = (k == 5) ? 32'hFFFF_FFFC : $urandom;
         bl  = (k == 5) ? 10'd3 : 10'($urandom_range(0, 5));
         if (k == 5) w = 2'd2;
         n   = (bl == 0) ? 1 : int'(bl);
         eb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         do_txn(cmd, w, a, bl, eb, -1, -1, 32'h0, int'($urandom_range(0, 2)));
         model_txn(cmd, w, a, bl, eb, -1);
      end
      do_txn(1'b0, 2'd2, 32'h0, 10'd1, -1, -1, 0, 32'h0, 2);
      model_txn(1'b0, 2'd2, 32'h0, 10'd1, -1, -1);
      foreach (exp_beat[i]) begin
         total++; if (i >= obs_beat.size() || obs_beat[i] !== exp_beat[i])
            $display("FAIL b2b beat%0d actual=%h required=%h", i, obs_beat[i], exp_beat[i]); else passed++;
      end
      foreach (exp_rsp[i]) begin
         total++; if (i >= obs_rsp.size() || obs_rsp[i] !== exp_rsp[i])
            $display("FAIL b2b resp%0d actual=%h required=%h", i, obs_rsp[i], exp_rsp[i]); else passed++;
      end
      total++; if (obs_beat.size() != exp_beat.size() || obs_rsp.size() != exp_rsp.size() ||
                   n_reqack != exp_nack || bad_ctl != 0)
         $display("FAIL b2b misc actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/0", obs_beat.size(),
                  obs_rsp.size(), n_reqack, bad_ctl, exp_beat.size(), exp_rsp.size(), exp_nack); else passed++;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_read_burst();
      test_byte_write();
      test_error_midburst();
      test_timeout();
      test_reset_in_wdat();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
